// File: rtl/coord_streamer_pkg.sv
// coord_pkg: shared FSM state and config-select encodings for coord_streamer
package coord_pkg;
  typedef enum logic [2:0] {IDLE, INIT, GAP, STREAM, DONE} state_t;
  typedef enum logic [1:0] {CFG_RE_BASE, CFG_IM_BASE, CFG_RE_STEP, CFG_IM_STEP} cfg_sel_t;
endpackage

// File: rtl/coord_streamer_if.sv
// coord_streamer_if: limb-serial coordinate link from the streamer to the solver
interface coord_streamer_if #(
  parameter int LIMB_BITS = 32,
  parameter int LIMB_INDEX_BITS = 6,
  parameter int PIX_BITS = 10
);
  logic c_val;
  logic c_rdy;
  logic c_last;
  logic [LIMB_BITS-1:0] cre_limb;
  logic [LIMB_BITS-1:0] cim_limb;
  logic [LIMB_INDEX_BITS-1:0] limb_ind;
  logic [PIX_BITS-1:0] pix_x;
  logic [PIX_BITS-1:0] pix_y;
  modport master(output c_val, c_last, cre_limb, cim_limb, limb_ind, pix_x, pix_y, input c_rdy);
  modport slave(input c_val, c_last, cre_limb, cim_limb, limb_ind, pix_x, pix_y, output c_rdy);
endinterface

// File: rtl/coord_streamer_limb_ram.sv
// limb_ram: one-write one-read limb storage with combinational read
module limb_ram #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [AW-1:0] raddr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/coord_streamer.sv
// coord_streamer: walks a pixel grid streaming multi-limb c=(re,im); optional abort via COORD_STREAMER_ABORT_EN
module coord_streamer import coord_pkg::*; #(
  parameter int LIMB_BITS = 32,
  parameter int LIMB_INDEX_BITS = 6,
  parameter int PIX_BITS = 10
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cfg_wr_en,
  input  logic [1:0]                 cfg_sel,
  input  logic [LIMB_INDEX_BITS-1:0] cfg_limb_ind,
  input  logic [LIMB_BITS-1:0]       cfg_data,
  input  logic [LIMB_INDEX_BITS-1:0] num_limbs,
  input  logic [PIX_BITS-1:0]        width,
  input  logic [PIX_BITS-1:0]        height,
  input  logic                       start,
`ifdef COORD_STREAMER_ABORT_EN
  input  logic                       abort,
`endif
  coord_streamer_if.master           c,
  output logic                       busy,
  output logic                       frame_done
);
  localparam int LB = LIMB_BITS;
  localparam int LI = LIMB_INDEX_BITS;
  localparam int PB = PIX_BITS;
  state_t state;
  logic [LI-1:0] i, nl;
  logic [PB-1:0] w, h, x, y;
  logic c_val, cy_re, cy_im;
  logic idle_like, ok_start, xfer, last_limb, last_x, last_y, abort_hit;
  logic [LB-1:0] cfg_rd [4];
  logic [LB-1:0] cur_re, cur_im, cur_re_wd, cur_im_wd;
  logic [LB:0] sum_re, sum_im;
  assign idle_like = state == IDLE || state == DONE;
  assign ok_start  = idle_like && start && num_limbs != '0 && width != '0 && height != '0;
  assign xfer      = c_val && c.c_rdy;
  assign last_limb = i == nl - LI'(1);
  assign last_x    = x == w - PB'(1);
  assign last_y    = y == h - PB'(1);
`ifdef COORD_STREAMER_ABORT_EN
  assign abort_hit = abort && busy;
`else
  assign abort_hit = 1'b0;
`endif
  // carry flops only chain within a pixel; limb 0 always starts fresh
  assign sum_re = {1'b0, cur_re} + {1'b0, cfg_rd[CFG_RE_STEP]} + (LB+1)'(i != '0 && cy_re);
  assign sum_im = {1'b0, cur_im} + {1'b0, cfg_rd[CFG_IM_STEP]} + (LB+1)'(i != '0 && cy_im);
  assign cur_re_wd = (state == INIT || last_x) ? cfg_rd[CFG_RE_BASE] : sum_re[LB-1:0];
  assign cur_im_wd = state == INIT ? cfg_rd[CFG_IM_BASE] : sum_im[LB-1:0];
  for (genvar g = 0; g < 4; g++) begin : g_cfg
    limb_ram #(.AW(LI), .DW(LB)) u_cfg (
      .clock(clock), .we(cfg_wr_en && idle_like && !ok_start && cfg_sel == 2'(g)),
      .waddr(cfg_limb_ind), .raddr(i), .wdata(cfg_data), .rdata(cfg_rd[g])
    );
  end
  limb_ram #(.AW(LI), .DW(LB)) u_cur_re (
    .clock(clock), .we(state == INIT || xfer), .waddr(i), .raddr(i), .wdata(cur_re_wd), .rdata(cur_re)
  );
  limb_ram #(.AW(LI), .DW(LB)) u_cur_im (
    .clock(clock), .we(state == INIT || (xfer && last_x)), .waddr(i), .raddr(i), .wdata(cur_im_wd), .rdata(cur_im)
  );
  assign c.c_val    = c_val;
  assign c.c_last   = c_val && last_limb;
  assign c.cre_limb = c_val ? cur_re : '0;
  assign c.cim_limb = c_val ? cur_im : '0;
  assign c.limb_ind = i;
  assign c.pix_x    = x;
  assign c.pix_y    = y;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      {i, nl, w, h, x, y} <= '0;
      {c_val, cy_re, cy_im, busy, frame_done} <= '0;
    end else if (abort_hit) begin
      state <= DONE;
      i <= '0;
      c_val <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: if (ok_start) begin
          state <= INIT;
          {nl, w, h} <= {num_limbs, width, height};
          {i, x, y} <= '0;
          busy <= 1'b1;
          frame_done <= 1'b0;
        end
        INIT: begin
          i <= last_limb ? '0 : i + LI'(1);
          state <= last_limb ? GAP : INIT;
        end
        GAP: begin
          state <= STREAM;
          c_val <= 1'b1;
        end
        STREAM: if (c.c_rdy) begin
          cy_re <= sum_re[LB];
          cy_im <= sum_im[LB];
          i <= last_limb ? '0 : i + LI'(1);
          if (last_limb) begin
            x <= last_x ? '0 : x + PB'(1);
            y <= last_x ? y + PB'(1) : y;
            c_val <= 1'b0;
            state <= (last_x && last_y) ? DONE : GAP;
            busy <= !(last_x && last_y);
            frame_done <= last_x && last_y;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
